// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache with burst refill and load hit/miss counters
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   cpu_req/we/addr/wdata    core load/store request; cpu_rdata returns load data
//   cpu_stall                core holds its request while high
//   flush                    invalidate every line (taken only when idle)
//   mem_req/we/addr/wdata    word-wide backing memory request, held until mem_ready
//   mem_ready                memory accepts the request
//   mem_rvalid/mem_rdata     refill beats, WORDS_PER_LINE per refill
//   hit_count/miss_count     saturating load hit/miss counters
module data_cache #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_LINES      = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  flush,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);
    localparam int WB  = $clog2(WORDS_PER_LINE);
    localparam int OFF = WB + 2;
    localparam int IDX = $clog2(NUM_LINES);
    localparam int TAG = ADDR_WIDTH - IDX - OFF;

    typedef enum logic [2:0] {IDLE, REFILL_REQ, REFILL_WAIT, WRITE, WDONE} state_t;

    state_t                state;
    logic [NUM_LINES-1:0]  valid;
    logic [TAG-1:0]        tags [NUM_LINES];
    logic [DATA_WIDTH-1:0] data [NUM_LINES][WORDS_PER_LINE];
    logic [WB-1:0]         beat;
    logic                  just_refilled;
    logic [IDX-1:0]        idx;
    logic [TAG-1:0]        tag;
    logic [WB-1:0]         word;
    logic                  hit;

    assign idx       = cpu_addr[OFF +: IDX];
    assign tag       = cpu_addr[ADDR_WIDTH-1 -: TAG];
    assign word      = cpu_addr[OFF-1:2];
    assign hit       = valid[idx] && tags[idx] == tag;
    assign cpu_rdata = data[idx][word];
    assign mem_req   = state == REFILL_REQ || state == WRITE;
    assign mem_we    = state == WRITE;
    assign mem_wdata = cpu_wdata;
    // Stores go out word-aligned; refills start at the line base.
    assign mem_addr  = cpu_addr & (mem_we ? ~ADDR_WIDTH'(3) : ~ADDR_WIDTH'(2**OFF - 1));

    // Only an idle load hit (and the store-retire cycle) lets the core proceed.
    always_comb
        cpu_stall = (state == IDLE) ? (flush || (cpu_req && (cpu_we || !hit))) : (state != WDONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            valid         <= '0;
            beat          <= '0;
            just_refilled <= 1'b0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    just_refilled <= 1'b0;
                    if (flush)
                        valid <= '0;
                    else if (cpu_req && cpu_we)
                        state <= WRITE;
                    else if (cpu_req && hit) begin
                        // The hit right after a refill is the missed load completing.
                        if (!just_refilled && hit_count != '1)
                            hit_count <= hit_count + 32'd1;
                    end else if (cpu_req) begin
                        if (miss_count != '1)
                            miss_count <= miss_count + 32'd1;
                        state <= REFILL_REQ;
                    end
                end
                REFILL_REQ: if (mem_ready) begin
                    beat  <= '0;
                    state <= REFILL_WAIT;
                end
                REFILL_WAIT: if (mem_rvalid) begin
                    beat <= beat + 1'b1;
                    // Valid only on the last beat so an aborted refill leaves the line invalid.
                    if (&beat) begin
                        valid[idx]    <= 1'b1;
                        just_refilled <= 1'b1;
                        state         <= IDLE;
                    end
                end
                WRITE:   if (mem_ready) state <= WDONE;
                WDONE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == REFILL_WAIT && mem_rvalid) begin
            data[idx][beat] <= mem_rdata;
            if (&beat)
                tags[idx] <= tag;
        end
        if (state == WRITE && mem_ready && hit)
            data[idx][word] <= cpu_wdata;
    end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: scoreboard bench for data_cache with a behavioural word-wide memory
module tb_data_cache;
    localparam int WPL = 4;

    logic        clk = 1'b0;
    logic        rst, cpu_req, cpu_we, flush, cpu_stall;
    logic        mem_req, mem_we, mem_ready, mem_rvalid;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] hit_count, miss_count;

    int          tests = 0, fails = 0;
    logic [31:0] mem_model [int];
    logic [31:0] exp_q [$];
    int          ready_delay = 0, wait_cnt = 0, beats_left = 0, req_count = 0, req_cycles = 0;
    logic [31:0] beat_addr, last_addr;
    logic        last_we;
    int          cyc, r0, m0, h0, n;
    logic [31:0] rd, e;
    logic        to;

    always #5 clk = ~clk;

    data_cache dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_model.exists(int'(a >> 2)) ? mem_model[int'(a >> 2)] : (a ^ 32'h5A5A_0000);
    endfunction

    // Memory responder: ready after ready_delay request cycles, then a back-to-back beat burst.
    initial begin
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0; mem_rvalid = 1'b0;
            if (rst) begin
                beats_left = 0; wait_cnt = 0;
            end else if (beats_left > 0) begin
                mem_rvalid = 1'b1; mem_rdata = mem_rd(beat_addr); beat_addr += 4; beats_left--;
            end else if (mem_req) begin
                req_cycles++;
                if (wait_cnt == ready_delay) begin
                    mem_ready = 1'b1; wait_cnt = 0; req_count++;
                    last_addr = mem_addr; last_we = mem_we;
                    if (mem_we) mem_model[int'(mem_addr >> 2)] = mem_wdata;
                    else begin beats_left = WPL; beat_addr = mem_addr; end
                end else wait_cnt++;
            end
        end
    end

    // Drive one access from a falling edge and wait (bounded) until the cache lets it through.
    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          output int c, output logic [31:0] r, output logic t);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        c = 0; t = 1'b0; r = 'x;
        #1;
        while (cpu_stall && c < 200) begin @(negedge clk); #1; c++; end
        if (cpu_stall) t = 1'b1; else r = cpu_rdata;
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; flush = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", cpu_stall); end
        tests++; if (hit_count !== 0 || miss_count !== 0) begin fails++; $display("FAIL reset_counters: got %h/%h expected 0/0", hit_count, miss_count); end
        @(negedge clk); #2 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_refill();
        r0 = req_count;
        exp_q.push_back(32'hA0);
        do_req(1'b0, 32'h100, '0, cyc, rd, to);
        e = exp_q.pop_front();
        tests++; if (rd !== e) begin fails++; $display("FAIL refill_rdata: got %h expected %h", rd, e); end
        tests++; if (cyc !== 6 || to) begin fails++; $display("FAIL refill_stall_cycles: got %0d expected 6", cyc); end
        tests++; if (req_count - r0 !== 1) begin fails++; $display("FAIL refill_requests: got %0d expected 1", req_count - r0); end
        tests++; if (last_addr !== 32'h100 || last_we !== 1'b0) begin fails++; $display("FAIL refill_addr: got %h we=%b expected 00000100 we=0", last_addr, last_we); end
        tests++; if (miss_count !== 1 || hit_count !== 0) begin fails++; $display("FAIL refill_counters: got %0d/%0d expected 0/1", hit_count, miss_count); end
    endtask

    task automatic test_hits_evict();
        for (int i = 1; i < 4; i++) begin
            exp_q.push_back(32'hA0 + i);
            do_req(1'b0, 32'h100 + 4 * i, '0, cyc, rd, to);
            e = exp_q.pop_front();
            tests++; if (rd !== e || cyc !== 0) begin fails++; $display("FAIL hit_word%0d: got %h stall=%0d expected %h stall=0", i, rd, cyc, e); end
        end
        tests++; if (hit_count !== 3) begin fails++; $display("FAIL hit_count: got %0d expected 3", hit_count); end
        exp_q.push_back(32'h5A5A_0500);
        exp_q.push_back(32'hA0);
        for (int i = 0; i < 2; i++) begin
            do_req(1'b0, i == 0 ? 32'h500 : 32'h100, '0, cyc, rd, to);
            e = exp_q.pop_front();
            tests++; if (rd !== e || cyc !== 6) begin fails++; $display("FAIL evict_load%0d: got %h stall=%0d expected %h stall=6", i, rd, cyc, e); end
        end
        tests++; if (miss_count !== 3 || hit_count !== 3) begin fails++; $display("FAIL evict_counters: got %0d/%0d expected 3/3", hit_count, miss_count); end
    endtask

    task automatic test_store();
        ready_delay = 3; r0 = req_cycles;
        do_req(1'b1, 32'h104, 32'hDEAD, cyc, rd, to);
        ready_delay = 0;
        tests++; if (req_cycles - r0 !== 4) begin fails++; $display("FAIL store_req_cycles: got %0d expected 4", req_cycles - r0); end
        tests++; if (cyc !== 5 || to) begin fails++; $display("FAIL store_stall_cycles: got %0d expected 5", cyc); end
        tests++; if (last_we !== 1'b1 || last_addr !== 32'h104 || mem_rd(32'h104) !== 32'hDEAD) begin fails++; $display("FAIL store_mem: got we=%b %h=%h expected we=1 00000104=0000dead", last_we, last_addr, mem_rd(32'h104)); end
        exp_q.push_back(32'hDEAD);
        do_req(1'b0, 32'h104, '0, cyc, rd, to);
        e = exp_q.pop_front();
        tests++; if (rd !== e || cyc !== 0) begin fails++; $display("FAIL store_update_hit: got %h stall=%0d expected %h stall=0", rd, cyc, e); end
        do_req(1'b1, 32'h2104, 32'h1234, cyc, rd, to);
        tests++; if (cyc !== 2 || mem_rd(32'h2104) !== 32'h1234) begin fails++; $display("FAIL store_miss: got stall=%0d mem=%h expected stall=2 mem=00001234", cyc, mem_rd(32'h2104)); end
        exp_q.push_back(32'hA2);
        do_req(1'b0, 32'h108, '0, cyc, rd, to);
        e = exp_q.pop_front();
        tests++; if (rd !== e || cyc !== 0) begin fails++; $display("FAIL store_no_allocate: got %h stall=%0d expected %h stall=0", rd, cyc, e); end
        tests++; if (hit_count !== 5 || miss_count !== 3) begin fails++; $display("FAIL store_counters: got %0d/%0d expected 5/3", hit_count, miss_count); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        #1;
        tests++; if (cpu_stall !== 1'b1) begin fails++; $display("FAIL flush_stall: got %b expected 1", cpu_stall); end
        @(negedge clk);
        flush = 1'b0;
        m0 = miss_count;
        exp_q.push_back(32'hA0);
        do_req(1'b0, 32'h100, '0, cyc, rd, to);
        e = exp_q.pop_front();
        tests++; if (rd !== e || cyc !== 6) begin fails++; $display("FAIL flush_reload: got %h stall=%0d expected %h stall=6", rd, cyc, e); end
        tests++; if (miss_count !== m0 + 1) begin fails++; $display("FAIL flush_miss_count: got %0d expected %0d", miss_count, m0 + 1); end
        // Evict, then raise flush mid-refill and drop it before the cache returns to idle.
        do_req(1'b0, 32'h500, '0, cyc, rd, to);
        h0 = hit_count;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; n = 0;
        do begin @(negedge clk); #1; n++; end while (beats_left == 0 && n < 50);
        @(negedge clk); #1; flush = 1'b1;
        do begin @(negedge clk); #1; n++; end while (beats_left != 0 && n < 50);
        flush = 1'b0;
        @(negedge clk); #1;
        tests++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'hA0 || n >= 50) begin fails++; $display("FAIL flush_in_refill: got stall=%b rdata=%h expected stall=0 rdata=000000a0", cpu_stall, cpu_rdata); end
        @(negedge clk); cpu_req = 1'b0;
        tests++; if (hit_count !== h0) begin fails++; $display("FAIL refill_hit_not_counted: got %0d expected %0d", hit_count, h0); end
    endtask

    task automatic test_reset_midrefill();
        r0 = req_count;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h700; n = 0;
        do begin @(negedge clk); #1; n++; end while (beats_left != 2 && n < 50);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        tests++; if (mem_req !== 1'b0 || cpu_stall !== 1'b1) begin fails++; $display("FAIL rst_mid_outputs: got mem_req=%b stall=%b expected 0/1", mem_req, cpu_stall); end
        tests++; if (hit_count !== 0 || miss_count !== 0) begin fails++; $display("FAIL rst_mid_counters: got %0d/%0d expected 0/0", hit_count, miss_count); end
        @(negedge clk); #2 rst = 1'b0;
        exp_q.push_back(32'h5A5A_0700);
        do_req(1'b0, 32'h700, '0, cyc, rd, to);
        e = exp_q.pop_front();
        tests++; if (rd !== e || cyc !== 6) begin fails++; $display("FAIL rst_reload: got %h stall=%0d expected %h stall=6", rd, cyc, e); end
        tests++; if (req_count - r0 !== 2 || last_addr !== 32'h700 || miss_count !== 1) begin fails++; $display("FAIL rst_new_request: got reqs=%0d addr=%h miss=%0d expected 2/00000700/1", req_count - r0, last_addr, miss_count); end
    endtask

    task automatic test_saturation();
        force dut.hit_count = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.hit_count;
        for (int i = 1; i < 4; i++) begin
            exp_q.push_back(32'h5A5A_0700 + 4 * i);
            do_req(1'b0, 32'h700 + 4 * i, '0, cyc, rd, to);
            e = exp_q.pop_front();
            tests++; if (rd !== e || hit_count !== 32'hFFFF_FFFF) begin fails++; $display("FAIL saturate%0d: got %h count=%h expected %h count=ffffffff", i, rd, hit_count, e); end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mem_model[64 + i] = 32'hA0 + i;
        test_reset();
        test_refill();
        test_hits_evict();
        test_store();
        test_flush();
        test_reset_midrefill();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate data cache between the core load/store port and a word-wide backing memory.
- Read hits return data combinationally in the same cycle, so the single-cycle datapath timing is kept.
- Misses and all stores stall the core through a handshake; line refills are bursts of WORDS_PER_LINE beats.
- Adds flush and hit/miss performance counters, which the plain data memory does not have.

Parameters:
- DATA_WIDTH, 32, word width; fixed at 32 (byte offset = 2 bits).
- ADDR_WIDTH, 32, byte address width.
- NUM_LINES, 64, number of lines; power of two, at least 2.
- WORDS_PER_LINE, 4, words per line; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- cpu_req  input  1  load/store access valid this cycle.
- cpu_we  input  1  1 = store, 0 = load.
- cpu_addr  input  ADDR_WIDTH  byte address; bits [1:0] ignored.
- cpu_wdata  input  DATA_WIDTH  store data.
- cpu_rdata  output  DATA_WIDTH  load data; valid when cpu_req & !cpu_we & !cpu_stall.
- cpu_stall  output  1  core must hold its request stable while this is 1.
- flush  input  1  invalidate all lines.
- mem_req  output  1  memory request valid.
- mem_we  output  1  memory request is a write.
- mem_addr  output  ADDR_WIDTH  memory request address.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_ready  input  1  memory accepts the request this cycle.
- mem_rvalid  input  1  refill beat valid.
- mem_rdata  input  DATA_WIDTH  refill beat data.
- hit_count  output  32  load hit counter, saturating.
- miss_count  output  32  load miss counter, saturating.

Behaviour:
- Address split:
  - OFF = log2(WORDS_PER_LINE)+2 bits.
  - IDX = log2(NUM_LINES) bits.
  - TAG = ADDR_WIDTH-IDX-OFF bits.
  - word select = addr[OFF-1:2].
- Per line: valid bit, tag, WORDS_PER_LINE data words; data/tag arrays are flops.
- hit = valid[idx] & tag[idx]==addr tag.
- Reset (async):
  - state IDLE, all valid bits 0, beat counter 0, just_refilled 0, counters 0.
  - mem_req 0, mem_we 0, cpu_stall 0 unless a request is present (combinational).
  - cpu_rdata is don't-care.
- FSM states: IDLE, REFILL_REQ, REFILL_WAIT, WRITE, WDONE.
- IDLE:
  - flush=1: stall=1; all valid bits clear next edge; stay IDLE. flush has priority over cpu_req.
  - Load hit: stall=0; cpu_rdata = line word, same cycle. hit_count +1 unless just_refilled=1.
  - Load miss: stall=1; miss_count +1; go to REFILL_REQ.
  - Store: stall=1; go to WRITE.
  - just_refilled clears on any IDLE cycle.
- REFILL_REQ:
  - stall=1; mem_req=1, mem_we=0, mem_addr = cpu_addr with low OFF bits zero.
  - On mem_ready, go to REFILL_WAIT with beat counter 0.
- REFILL_WAIT:
  - stall=1; mem_req=0.
  - Each mem_rvalid writes mem_rdata into word[beat] of the indexed line and increments beat.
  - On the beat WORDS_PER_LINE-1: set tag and valid, set just_refilled, go to IDLE.
  - The next cycle hits with stall=0 and does not count as a hit.
  - mem_rvalid outside REFILL_WAIT is ignored.
- WRITE:
  - stall=1; mem_req=1, mem_we=1, mem_addr = cpu_addr word-aligned, mem_wdata = cpu_wdata.
  - On mem_ready: if hit, update the cached word (valid and tag unchanged); go to WDONE.
  - On a miss, no allocation.
- WDONE:
  - stall=0 for exactly one cycle so the core retires the store; then IDLE.
  - No memory request in this state.
- flush outside IDLE is ignored. The core must hold it until it is taken.
- Counters saturate at 32'hFFFF_FFFF. Store accesses are not counted.
- Reset mid-refill or mid-write: returns to IDLE immediately. The partially filled line stays invalid, because valid is set only on the last beat.
- mem_req holds stable until mem_ready. mem_ready while mem_req=0 is ignored.
- Latency:
  - Load hit: 0 stall cycles.
  - Load miss: 1 + request-wait + WORDS_PER_LINE beats, plus 1 cycle.
  - Store: 1 + request-wait + 1.

Test Plan:
- Reset, then load 0x100 with mem_ready=1 and 4 consecutive beats 0xA0..0xA3: mem_addr=0x100, one request, rdata=0xA0 on the hit cycle. miss_count=1, hit_count=0.
- After the line is filled, loads 0x104, 0x108, 0x10C: each stall=0 with rdata 0xA1, 0xA2, 0xA3; hit_count=3. Load 0x100+NUM_LINES*16 (same index, different tag) misses and evicts; reload 0x100 misses again.
- Store 0x104 = 0xDEAD on a cached line with mem_ready delayed 3 cycles: mem_req/mem_we held for 4 cycles, one WDONE cycle with stall=0. Later load 0x104 hits with 0xDEAD. Store to an uncached address leaves valid unchanged.
- flush in IDLE after filling: stall=1 for 1 cycle; next load of 0x100 misses and miss_count increments. flush asserted during REFILL_WAIT is ignored until IDLE.
- Assert rst after 2 of 4 refill beats: state IDLE, mem_req=0, counters 0. Load 0x100 misses and issues a new refill request.
- Preload hit_count to 0xFFFF_FFFE via repeated hits (or force), then 3 hits: counter stays at 0xFFFF_FFFF.
